// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
//
// Shared types and constants for the neuron accumulation stage.
//
// Contents:
//   DEF_N_IN / DEF_W     default lane count and lane width
//   DEF_ACC_W            accumulator width that cannot overflow while summing
//                        DEF_N_IN+1 unsigned DEF_W-bit lanes
//   DEF_IDX_W            width of the lane index counter
//   lane_vec_t           product vector, lane i = product i, lane N_IN = bias
//   state_t              accumulator FSM states
//   sat_result_t         W-bit result plus saturation flag
//   sat_trunc()          narrows an accumulator value to W bits, clamping to
//                        all-ones when any bit above W is set
//
// Optional feature macro used by the consumers of this package:
//   NEURON_ACC_SAT_EN    saturate the neuron sum instead of wrapping it
// -----------------------------------------------------------------------------
package neuron_pkg;

    localparam int DEF_N_IN  = 32;
    localparam int DEF_W     = 32;
    localparam int DEF_IDX_W = $clog2(DEF_N_IN + 1);
    localparam int DEF_ACC_W = DEF_W + DEF_IDX_W;

    typedef logic [DEF_N_IN:0][DEF_W-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_W-1:0] sum;
        logic             sat;
    } sat_result_t;

    // Clamp a default-sized accumulator value into DEF_W bits. Any carry into
    // the guard bits means the true sum does not fit, so the result pins at
    // the largest representable value and the flag is raised.
    function automatic sat_result_t sat_trunc(input logic [DEF_ACC_W-1:0] acc);
        sat_result_t r;
        r.sat = |acc[DEF_ACC_W-1:DEF_W];
        r.sum = r.sat ? {DEF_W{1'b1}} : acc[DEF_W-1:0];
        return r;
    endfunction

endpackage : neuron_pkg

// File: rtl/neuron_accumulator.sv
// -----------------------------------------------------------------------------
// neuron_accumulator
//
// Accepts one vector of N_IN+1 unsigned products (N_IN weighted inputs plus
// the bias lane N_IN) over a valid/ready handshake, sums the lanes serially in
// ascending order, one lane per clock, in an accumulator wide enough never to
// overflow, and returns the W-bit neuron pre-activation sum over a second
// valid/ready handshake.
//
// Timing at defaults (N_IN = 32):
//   accept edge -> 33 accumulate edges -> out_valid high.
//   With out_ready tied high a new vector can be taken every 35 cycles.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   product vector valid
//   in_ready   out  block is IDLE and can take a vector (low during reset)
//   in_data    in   [N_IN:0][W-1:0] product vector, snapshotted on accept
//   out_valid  out  neuron sum valid (state DONE)
//   out_ready  in   downstream takes the sum
//   out_sum    out  [W-1:0] neuron sum, stable while out_valid is high
//   out_sat    out  sum did not fit in W bits
//
// Build option:
//   NEURON_ACC_SAT_EN defined   -> out_sum saturates to all-ones and out_sat
//                                  flags the event.
//   NEURON_ACC_SAT_EN undefined -> out_sum is the sum modulo 2**W and out_sat
//                                  is a constant 0.
// -----------------------------------------------------------------------------
module neuron_accumulator
    import neuron_pkg::*;
#(
    parameter int N_IN = DEF_N_IN,
    parameter int W    = DEF_W
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN:0][W-1:0]  in_data,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_sum,
    output logic                  out_sat
);

    localparam int IDX_W = $clog2(N_IN + 1);
    localparam int ACC_W = W + IDX_W;

    // Index of the bias lane, which is also the last lane summed.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN);

    state_t                 state_q;
    state_t                 state_d;

    logic [N_IN:0][W-1:0]   lane_buf_q;
    logic [ACC_W-1:0]       acc_q;
    logic [IDX_W-1:0]       idx_q;

    logic                   accept;
    logic                   last_lane;
    logic [ACC_W-1:0]       acc_sum;
    logic [W-1:0]           res_sum;

    assign accept    = in_valid & in_ready;
    assign last_lane = (state_q == ACCUM) && (idx_q == LAST_IDX);

    // Running sum including the lane selected this cycle; on the last lane
    // this is the complete neuron sum, so the result is formed from it
    // directly rather than waiting a cycle for acc_q to catch up.
    assign acc_sum = acc_q + ACC_W'(lane_buf_q[idx_q]);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from pre-edge values, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)              state_d = ACCUM;
            ACCUM:   if (idx_q == LAST_IDX)   state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // in_ready is gated by rst_n so upstream never sees a ready that cannot
    // be honoured while the block is held in reset.
    always_comb begin
        in_ready  = (state_q == IDLE) && rst_n;
        out_valid = (state_q == DONE);
    end

    // -------------------------------------------------------------------------
    // Datapath: lane buffer, index counter, accumulator, result register
    // -------------------------------------------------------------------------
    // NOTE: the lane buffer is reset along with the rest of the datapath so a
    // reset leaves no stale product data visible anywhere in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_buf_q <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            out_sum    <= '0;
        end else begin
            if (accept) begin
                // Snapshot the whole vector; in_data is don't-care afterwards.
                lane_buf_q <= in_data;
                acc_q      <= '0;
                idx_q      <= '0;
            end else if (state_q == ACCUM) begin
                acc_q <= acc_sum;
                // Hold the index on the bias lane so it never points past the
                // buffer while the result waits in DONE.
                if (!last_lane) begin
                    idx_q <= idx_q + IDX_W'(1);
                end
                if (last_lane) begin
                    out_sum <= res_sum;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result formation
    // -------------------------------------------------------------------------
`ifdef NEURON_ACC_SAT_EN
    logic res_sat;

    // Any set bit above W means the true sum cannot be represented.
    always_comb begin
        res_sat = |acc_sum[ACC_W-1:W];
        res_sum = res_sat ? {W{1'b1}} : acc_sum[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sat <= 1'b0;
        end else if (last_lane) begin
            out_sat <= res_sat;
        end
    end
`else
    // Modulo-2**W wrap: the guard bits are simply dropped.
    assign res_sum = acc_sum[W-1:0];
    assign out_sat = 1'b0;
`endif

endmodule : neuron_accumulator

// File: tb/tb_neuron_accumulator.sv
// -----------------------------------------------------------------------------
// tb_neuron_accumulator
//
// Directed self-checking bench for neuron_accumulator at default parameters.
// Expected sums are hand-computed; the saturation scenarios select their
// expected values according to NEURON_ACC_SAT_EN.
// -----------------------------------------------------------------------------
module tb_neuron_accumulator;
    import neuron_pkg::*;

    localparam int N_IN = DEF_N_IN;
    localparam int W    = DEF_W;
    localparam int LAT  = N_IN + 1;   // edges from accept to out_valid

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    lane_vec_t     in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_accumulator #(
        .N_IN (N_IN),
        .W    (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat)
    );

    // Offer a vector for one edge, then scramble in_data and count edges
    // after the accepting edge until out_valid is seen (-1 on timeout).
    task automatic send_and_wait(input lane_vec_t v, output bit accepted, output int edges);
        @(negedge clk);
        in_data  = v;
        in_valid = 1'b1;
        accepted = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {(N_IN+1){32'hDEAD_BEEF}};
        edges = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_sum !== '0)     begin errors++; $display("FAIL reset_out_sum: got %h expected 0", out_sum); end
        checks++; if (out_sat !== 1'b0)   begin errors++; $display("FAIL reset_out_sat: got %b expected 0", out_sat); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_ones();
        bit acc_ok;
        int edges;
        send_and_wait({(N_IN+1){32'h1}}, acc_ok, edges);
        checks++; if (acc_ok !== 1'b1)      begin errors++; $display("FAIL ones_accept: got %b expected 1", acc_ok); end
        checks++; if (edges != LAT)         begin errors++; $display("FAIL ones_latency: got %0d expected %0d", edges, LAT); end
        checks++; if (out_sum !== 32'd33)   begin errors++; $display("FAIL ones_sum: got %0d expected 33", out_sum); end
        checks++; if (out_sat !== 1'b0)     begin errors++; $display("FAIL ones_sat: got %b expected 0", out_sat); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL ones_valid_clear: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL ones_ready_back: got %b expected 1", in_ready); end
    endtask

    task automatic test_ramp();
        lane_vec_t v;
        bit acc_ok;
        int edges;
        for (int k = 0; k <= N_IN; k++) v[k] = W'(k);
        send_and_wait(v, acc_ok, edges);
        checks++; if (edges != LAT)         begin errors++; $display("FAIL ramp_latency: got %0d expected %0d", edges, LAT); end
        checks++; if (out_sum !== 32'd528)  begin errors++; $display("FAIL ramp_sum: got %0d expected 528", out_sum); end
        checks++; if (out_sat !== 1'b0)     begin errors++; $display("FAIL ramp_sat: got %b expected 0", out_sat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sat_two();
        lane_vec_t v;
        bit acc_ok;
        int edges;
        logic [W-1:0] exp_sum;
        logic         exp_sat;
`ifdef NEURON_ACC_SAT_EN
        exp_sum = 32'hFFFF_FFFF;
        exp_sat = 1'b1;
`else
        exp_sum = 32'h0000_0000;
        exp_sat = 1'b0;
`endif
        v    = '0;
        v[0] = 32'h8000_0000;
        v[1] = 32'h8000_0000;
        send_and_wait(v, acc_ok, edges);
        checks++; if (out_sum !== exp_sum)  begin errors++; $display("FAIL sat_two_sum: got %h expected %h", out_sum, exp_sum); end
        checks++; if (out_sat !== exp_sat)  begin errors++; $display("FAIL sat_two_sat: got %b expected %b", out_sat, exp_sat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_ones();
        bit acc_ok;
        int edges;
        logic [W-1:0] exp_sum;
        logic         exp_sat;
`ifdef NEURON_ACC_SAT_EN
        exp_sum = 32'hFFFF_FFFF;
        exp_sat = 1'b1;
`else
        exp_sum = 32'hFFFF_FFDF;
        exp_sat = 1'b0;
`endif
        send_and_wait({(N_IN+1){32'hFFFF_FFFF}}, acc_ok, edges);
        checks++; if (out_sum !== exp_sum)  begin errors++; $display("FAIL all_ones_sum: got %h expected %h", out_sum, exp_sum); end
        checks++; if (out_sat !== exp_sat)  begin errors++; $display("FAIL all_ones_sat: got %b expected %b", out_sat, exp_sat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bit acc_ok;
        int edges;
        int bad_stable = 0;
        out_ready = 1'b0;
        send_and_wait({(N_IN+1){32'd5}}, acc_ok, edges);
        checks++; if (out_sum !== 32'd165)  begin errors++; $display("FAIL bp_first_sum: got %0d expected 165", out_sum); end
        // Hold the result while upstream offers a new vector.
        in_valid = 1'b1;
        in_data  = {(N_IN+1){32'd7}};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_sum !== 32'd165 || in_ready !== 1'b0) begin
                bad_stable++;
                $display("FAIL bp_hold cycle %0d: valid=%b sum=%0d ready=%b expected 1/165/0", c, out_valid, out_sum, in_ready);
            end
        end
        checks++; if (bad_stable != 0) errors++;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        @(posedge clk);   // held in_valid is accepted on this edge
        #1;
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL bp_second_accept: in_ready got %b expected 0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {(N_IN+1){32'hDEAD_BEEF}};
        edges = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                edges = n;
                break;
            end
        end
        checks++; if (edges != LAT)         begin errors++; $display("FAIL bp_second_latency: got %0d expected %0d", edges, LAT); end
        checks++; if (out_sum !== 32'd231)  begin errors++; $display("FAIL bp_second_sum: got %0d expected 231", out_sum); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit acc_ok;
        int edges;
        @(negedge clk);
        in_data  = {(N_IN+1){32'd3}};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        checks++; if (out_sum !== '0)       begin errors++; $display("FAIL midrst_sum: got %h expected 0", out_sum); end
        checks++; if (out_sat !== 1'b0)     begin errors++; $display("FAIL midrst_sat: got %b expected 0", out_sat); end
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL midrst_ready: got %b expected 0", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL midrst_ready_held: got %b expected 0", in_ready); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_and_wait({(N_IN+1){32'd2}}, acc_ok, edges);
        checks++; if (acc_ok !== 1'b1)      begin errors++; $display("FAIL midrst_accept: got %b expected 1", acc_ok); end
        checks++; if (edges != LAT)         begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", edges, LAT); end
        checks++; if (out_sum !== 32'd66)   begin errors++; $display("FAIL midrst_sum: got %0d expected 66", out_sum); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_ones();
        test_ramp();
        test_sat_two();
        test_all_ones();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_neuron_accumulator
